lcd_bus_writer: RTL and testbench

Single-byte HD44780 bus write engine sitting directly downstream of the LCD message sequencer. It accepts one byte plus register-select through a 4-phase start/done handshake, drives the 8-bit LCD data bus with correct setup, enable-pulse and hold timing, waits out the controller execution time, then signals completion. It is the only block that touches the LCD pins.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_cycle_timer.sv | 33 +++
 rtl/lcd_bus_writer.sv | 144 ++++++++++++++
 tb/tb_lcd_bus_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus write engine.
// Build option: LCD_WRITER_LONG_EXEC_EN enables the clear/home command decode.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StExec,
        StDone
    } lcd_wr_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Default timing in cycles of a 50 MHz clock.
    localparam int unsigned LCD_T_SETUP     = 3;
    localparam int unsigned LCD_T_EN        = 16;
    localparam int unsigned LCD_T_HOLD      = 2;
    localparam int unsigned LCD_T_EXEC      = 2000;
    localparam int unsigned LCD_T_EXEC_LONG = 82000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

`ifdef LCD_WRITER_LONG_EXEC_EN
    // Clear is 8'h01; return home ignores bit 0 (8'h02 / 8'h03).
    function automatic logic is_long_exec_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data[7:1] == LCD_CMD_HOME[7:1]));
    endfunction
`endif

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module lcd_cycle_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// Single-byte HD44780 write engine: setup, enable pulse, hold, execution wait, done handshake.
// Build option: LCD_WRITER_LONG_EXEC_EN selects T_EXEC_LONG for clear/home commands.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP     = LCD_T_SETUP,
    parameter int unsigned T_EN        = LCD_T_EN,
    parameter int unsigned T_HOLD      = LCD_T_HOLD,
    parameter int unsigned T_EXEC      = LCD_T_EXEC,
    parameter int unsigned T_EXEC_LONG = LCD_T_EXEC_LONG
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    localparam int unsigned CntW = $clog2(max_u(T_EXEC, T_EXEC_LONG) + 1);

    // Counter is loaded with N-1 so each phase lasts exactly N cycles.
    localparam logic [CntW-1:0] SetupLd = CntW'(T_SETUP - 1);
    localparam logic [CntW-1:0] EnLd    = CntW'(T_EN - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(T_HOLD - 1);
    localparam logic [CntW-1:0] ExecLd  = CntW'(T_EXEC - 1);
`ifdef LCD_WRITER_LONG_EXEC_EN
    localparam logic [CntW-1:0] LongLd  = CntW'(T_EXEC_LONG - 1);
`endif

    lcd_wr_state_t state_d, state_q;
    logic [7:0]    data_d, data_q;
    logic          rs_d, rs_q;
    logic          en_d, en_q;
    logic          done_d, done_q;

    logic            tmr_load;
    logic [CntW-1:0] tmr_load_val;
    logic            tmr_zero;

    lcd_cycle_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        rs_d         = rs_q;
        en_d         = en_q;
        done_d       = done_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    data_d       = iDATA;
                    rs_d         = iRS;
                    tmr_load     = 1'b1;
                    tmr_load_val = SetupLd;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    en_d         = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = EnLd;
                    state_d      = StPulse;
                end
            end
            StPulse: begin
                if (tmr_zero) begin
                    en_d         = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = HoldLd;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
`ifdef LCD_WRITER_LONG_EXEC_EN
                    tmr_load_val = is_long_exec_cmd(rs_q, data_q) ? LongLd : ExecLd;
`else
                    tmr_load_val = ExecLd;
`endif
                    state_d = StExec;
                end
            end
            StExec: begin
                if (tmr_zero) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Leaving DONE consumes the edge; a new request waits for IDLE.
                if (!iStart) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                en_d    = 1'b0;
                done_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= StIdle;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = en_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Randomised and directed bench for lcd_bus_writer against a timeline-based reference model.
`timescale 1ns/1ps
module tb_lcd_bus_writer;

    localparam int TS = 3;
    localparam int TE = 16;
    localparam int TH = 2;
    localparam int TX = 2000;
    localparam int TL = 5000;
    localparam int LIMIT = 20000;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] iDATA = 8'h00;
    logic       iRS = 1'b0;
    logic       iStart = 1'b0;
    logic       oDone;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;
    int en_rises = 0;
    logic en_prev = 1'b0;

    always #5 iCLK = ~iCLK;

    lcd_bus_writer #(
        .T_SETUP     (TS),
        .T_EN        (TE),
        .T_HOLD      (TH),
        .T_EXEC      (TX),
        .T_EXEC_LONG (TL)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iDATA    (iDATA),
        .iRS      (iRS),
        .iStart   (iStart),
        .oDone    (oDone),
        .LCD_DATA (LCD_DATA),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_exec(input logic [7:0] d, input logic r);
`ifdef LCD_WRITER_LONG_EXEC_EN
        if (!r && (d == 8'd1 || d == 8'd2 || d == 8'd3)) return TL;
`endif
        return TX;
    endfunction

    // Reference model: a write is a timeline measured from its acceptance edge.
    int         n = 0;
    int         m_state = 0;  // 0 idle, 1 writing, 2 done
    int         m_t0 = 0;
    int         m_tx = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_rs = 1'b0;

    always @(posedge iCLK) begin
        n = n + 1;
        if (iRST) begin
            m_state = 0;
            m_data  = 8'h00;
            m_rs    = 1'b0;
        end else begin
            case (m_state)
                0: if (iStart) begin
                    m_state = 1;
                    m_t0    = n;
                    m_data  = iDATA;
                    m_rs    = iRS;
                    m_tx    = exp_exec(iDATA, iRS);
                end
                1: if (n - m_t0 == TS + TE + TH + m_tx) m_state = 2;
                default: if (!iStart) m_state = 0;
            endcase
        end
    end

    always @(posedge iCLK) begin
        int  rel;
        logic exp_en;
        #1;
        if (LCD_EN === 1'b1 && en_prev !== 1'b1) en_rises++;
        en_prev = LCD_EN;
        if (chk_on) begin
            rel    = n - m_t0;
            exp_en = (m_state == 1) && (rel >= TS) && (rel < TS + TE);
            check("model_en", 32'(LCD_EN), 32'(exp_en));
            check("model_done", 32'(oDone), 32'(m_state == 2));
            check("model_data", 32'(LCD_DATA), 32'(m_data));
            check("model_rs", 32'(LCD_RS), 32'(m_rs));
            check("model_rw", 32'(LCD_RW), 32'd0);
        end
    end

    // One write with upstream holding iStart until oDone plus 'extra' cycles.
    // Edge offsets are relative to the acceptance edge E0.
    task automatic run_write(input logic [7:0] d, input logic r, input int extra,
                             output int rise, output int fall, output int dn);
        int k;
        rise = -1; fall = -1; dn = -1;
        @(posedge iCLK); #2;
        iDATA = d; iRS = r; iStart = 1'b1;
        k = -1;
        while (dn < 0 && k < LIMIT) begin
            @(posedge iCLK); #1;
            k++;
            if (k == 0) begin
                iDATA = 8'($urandom);
                iRS   = 1'($urandom);
            end
            if (LCD_EN === 1'b1 && rise < 0) rise = k;
            if (LCD_EN === 1'b0 && rise >= 0 && fall < 0) fall = k;
            if (oDone === 1'b1) dn = k;
        end
        if (dn < 0) check("done_timeout", 32'd0, 32'd1);
        for (int i = 0; i < extra; i++) begin
            @(posedge iCLK); #1;
            check("done_held", 32'(oDone), 32'd1);
        end
        #1 iStart = 1'b0;
        @(posedge iCLK); #1;
        check("done_fall", 32'(oDone), 32'd0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, fall, dn, k, hi, len;
        logic [7:0] d;
        logic r;

        repeat (3) @(posedge iCLK);
        #1;
        check("rst_en", 32'(LCD_EN), 32'd0);
        check("rst_data", 32'(LCD_DATA), 32'd0);
        check("rst_rs", 32'(LCD_RS), 32'd0);
        check("rst_rw", 32'(LCD_RW), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        iRST = 1'b0;
        chk_on = 1'b1;

        // Ordinary data write with 5 extra held cycles.
        run_write(8'h48, 1'b1, 5, rise, fall, dn);
        check("w48_en_rise", 32'(rise), 32'd3);
        check("w48_en_fall", 32'(fall), 32'd19);
        check("w48_done", 32'(dn), 32'd2021);
        check("w48_pulses", 32'(en_rises), 32'd1);
        check("w48_data_idle", 32'(LCD_DATA), 32'h48);

        // Back-to-back writes, iStart dropped on oDone.
        run_write(8'h38, 1'b0, 0, rise, fall, dn);
        check("w38_done", 32'(dn), 32'd2021);
        check("w38_data_idle", 32'(LCD_DATA), 32'h38);
        run_write(8'h0C, 1'b0, 0, rise, fall, dn);
        check("w0c_done", 32'(dn), 32'd2021);
        check("b2b_pulses", 32'(en_rises), 32'd3);
        check("w0c_data_idle", 32'(LCD_DATA), 32'h0C);

        // Clear command and a data byte with the same value.
        run_write(8'h01, 1'b0, 0, rise, fall, dn);
`ifdef LCD_WRITER_LONG_EXEC_EN
        check("clear_done", 32'(dn), 32'(21 + TL));
`else
        check("clear_done", 32'(dn), 32'd2021);
`endif
        run_write(8'h01, 1'b1, 0, rise, fall, dn);
        check("data01_done", 32'(dn), 32'd2021);

        // Reset during the enable pulse.
        @(posedge iCLK); #2;
        iDATA = 8'hC3; iRS = 1'b1; iStart = 1'b1;
        @(posedge iCLK);
        repeat (9) @(posedge iCLK);
        #1;
        check("pre_rst_en", 32'(LCD_EN), 32'd1);
        #1 iRST = 1'b1;
        @(posedge iCLK); #1;
        check("mid_rst_en", 32'(LCD_EN), 32'd0);
        check("mid_rst_data", 32'(LCD_DATA), 32'd0);
        check("mid_rst_rs", 32'(LCD_RS), 32'd0);
        check("mid_rst_done", 32'(oDone), 32'd0);
        #1 iRST = 1'b0; iStart = 1'b0;
        run_write(8'hA5, 1'b1, 0, rise, fall, dn);
        check("post_rst_rise", 32'(rise), 32'd3);
        check("post_rst_done", 32'(dn), 32'd2021);

        // iStart high for the acceptance edge only.
        @(posedge iCLK); #2;
        iDATA = 8'h5A; iRS = 1'b1; iStart = 1'b1;
        @(posedge iCLK); #2;
        iStart = 1'b0;
        k = 0;
        while (oDone !== 1'b1 && k < LIMIT) begin
            @(posedge iCLK); #1;
            k++;
        end
        check("pulse_done", 32'(k), 32'd2021);
        hi = 0;
        while (oDone === 1'b1 && hi < 10) begin
            hi++;
            @(posedge iCLK); #1;
        end
        check("pulse_done_width", 32'(hi), 32'd1);

        // Randomised writes and handshake shapes, checked by the model.
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            r = 1'($urandom);
            if (($urandom & 1) == 0) begin
                run_write(d, r, int'($urandom_range(0, 3)), rise, fall, dn);
                check("rnd_done", 32'(dn), 32'(TS + TE + TH + exp_exec(d, r)));
            end else begin
                len = int'($urandom_range(1, 5));
                @(posedge iCLK); #2;
                iDATA = d; iRS = r; iStart = 1'b1;
                repeat (len) @(posedge iCLK);
                #2 iStart = 1'b0;
                k = 0;
                while (oDone !== 1'b1 && k < LIMIT) begin
                    @(posedge iCLK); #1;
                    k++;
                end
                check("rnd_short_done", 32'(oDone), 32'd1);
                @(posedge iCLK); #1;
                check("rnd_short_fall", 32'(oDone), 32'd0);
            end
            repeat ($urandom_range(0, 3)) @(posedge iCLK);
        end

        repeat (3) @(posedge iCLK);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
